// File: rtl/aes_load_interface.sv
// ============================================================================
// Module  : aes_load_interface
// Brief   : Beat-serial plaintext/key loader with valid/ready handshake that
//           launches the AES engine and holds operands until it completes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_load_interface #(
    parameter int IN_W  = 8,
    parameter int KEY_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   din,
    input  logic [1:0]        cmd,
    input  logic              din_valid,
    output logic              ready,
    input  logic              engine_done,
    output logic              key_start,
    output logic [127:0]      plain_out,
    output logic [KEY_W-1:0]  key_out,
    output logic              plain_loaded,
    output logic              key_loaded,
    output logic              err
);

    localparam int P_BEATS   = 128 / IN_W;
    localparam int K_BEATS   = KEY_W / IN_W;
    localparam int MAX_BEATS = (K_BEATS > P_BEATS) ? K_BEATS : P_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS) + 1;

    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_p_last = CNT_W'(P_BEATS - 1);
    localparam logic [CNT_W-1:0] c_k_last = CNT_W'(K_BEATS - 1);

    localparam logic [1:0] c_cmd_abort = 2'b00;
    localparam logic [1:0] c_cmd_plain = 2'b01;
    localparam logic [1:0] c_cmd_key   = 2'b10;
    localparam logic [1:0] c_cmd_start = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_P = 2'd1,
        ST_LOAD_K = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    assign w_accept = din_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            plain_out    <= '0;
            key_out      <= '0;
            plain_loaded <= 1'b0;
            key_loaded   <= 1'b0;
            key_start    <= 1'b0;
            err          <= 1'b0;
            ready        <= 1'b1;
        end else begin
            key_start <= 1'b0;
            err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (cmd)
                            c_cmd_plain: begin
                                // First beat restarts the register from scratch.
                                plain_out    <= {{(128-IN_W){1'b0}}, din};
                                plain_loaded <= 1'b0;
                                r_cnt        <= c_one;
                                r_state      <= ST_LOAD_P;
                            end
                            c_cmd_key: begin
                                key_out    <= {{(KEY_W-IN_W){1'b0}}, din};
                                key_loaded <= 1'b0;
                                r_cnt      <= c_one;
                                r_state    <= ST_LOAD_K;
                            end
                            c_cmd_start: begin
                                if (plain_loaded && key_loaded) begin
                                    key_start <= 1'b1;
                                    ready     <= 1'b0;
                                    r_state   <= ST_RUN;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD_P: begin
                    if (w_accept) begin
                        case (cmd)
                            c_cmd_plain: begin
                                plain_out <= {plain_out[127-IN_W:0], din};
                                r_cnt     <= r_cnt + c_one;
                                if (r_cnt == c_p_last) begin
                                    plain_loaded <= 1'b1;
                                    r_state      <= ST_IDLE;
                                end
                            end
                            c_cmd_abort: begin
                                plain_out    <= '0;
                                plain_loaded <= 1'b0;
                                r_cnt        <= '0;
                                r_state      <= ST_IDLE;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ST_LOAD_K: begin
                    if (w_accept) begin
                        case (cmd)
                            c_cmd_key: begin
                                key_out <= {key_out[KEY_W-1-IN_W:0], din};
                                r_cnt   <= r_cnt + c_one;
                                if (r_cnt == c_k_last) begin
                                    key_loaded <= 1'b1;
                                    r_state    <= ST_IDLE;
                                end
                            end
                            c_cmd_abort: begin
                                key_out    <= '0;
                                key_loaded <= 1'b0;
                                r_cnt      <= '0;
                                r_state    <= ST_IDLE;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ST_RUN: begin
                    // Key stays resident so the next block only needs new plaintext.
                    if (engine_done) begin
                        plain_out    <= '0;
                        plain_loaded <= 1'b0;
                        ready        <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
